display_sched: RTL and testbench

DISPLAY_SCHED -- requirements
Module: display_sched

---
 rtl/display_sched.sv | 99 +++++++++
 tb/tb_display_sched.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/display_sched.sv
// display_sched: prioritised 4-digit display scheduler with BCD conversion and scan (LEAD_ZERO_BLANK_EN blanks leading zeros)
module display_sched #(
  parameter int SCAN_DIV   = 500,
  parameter int HOLD_TICKS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [15:0] msg,
  output logic [2:0]  grant,
  output logic        busy,
  output logic        conv_done,
  output logic [3:0]  digit,
  output logic [1:0]  pos
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_TICKS - 1);
  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;
  state_t state_q;
  logic [SW-1:0] scan_q;
  logic [HW-1:0] hold_q;
  logic [3:0] bit_q, digit_q;
  logic [15:0] bin_q, bcd_q, disp_q, disp_d, src, sat, adj, bcd_d, conv_val;
  logic [1:0] pos_q, pos_d;
  logic [2:0] grant_q, win, higher;
  logic tick, expire, rearb, ld_msg, ld_conv, conv_done_q;
  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign adj[4*i+:4] = bcd_q[4*i+:4] + (bcd_q[4*i+:4] >= 4'd5 ? 4'd3 : 4'd0);
  end
  assign bcd_d = {adj[14:0], bin_q[15]};
`ifdef LEAD_ZERO_BLANK_EN
  assign conv_val = {bcd_d[15:12] == 4'd0 ? 4'hf : bcd_d[15:12],
                     bcd_d[15:8] == 8'd0 ? 4'hf : bcd_d[11:8],
                     bcd_d[15:4] == 12'd0 ? 4'hf : bcd_d[7:4],
                     bcd_d[3:0]};
`else
  assign conv_val = bcd_d;
`endif
  assign tick = scan_q == SMAX;
  assign expire = hold_q == HMAX;
  assign win = req[2] ? 3'b100 : req[1] ? 3'b010 : {2'b00, req[0]};
  assign higher = req & ~((grant_q << 1) - 3'd1);
  assign src = win[1] ? val1 : val0;
  assign sat = src > 16'd9999 ? 16'd9999 : src;
  assign rearb = state_q == IDLE || (state_q == SHOW && tick && (expire || higher != 3'd0));
  assign ld_msg = rearb && win[2];
  assign ld_conv = state_q == CONV && bit_q == 4'd15;
  assign disp_d = ld_msg ? msg : ld_conv ? conv_val : disp_q;
  assign pos_d = pos_q + {1'b0, tick};
  assign grant = grant_q;
  assign busy = state_q == CONV;
  assign conv_done = conv_done_q;
  assign digit = digit_q;
  assign pos = pos_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      scan_q      <= '0;
      hold_q      <= '0;
      bit_q       <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      disp_q      <= '0;
      pos_q       <= '0;
      digit_q     <= '0;
      grant_q     <= '0;
      conv_done_q <= 1'b0;
    end else begin
      scan_q      <= tick ? '0 : scan_q + 1'b1;
      pos_q       <= pos_d;
      digit_q     <= disp_d[{pos_d, 2'b00}+:4];
      disp_q      <= disp_d;
      conv_done_q <= ld_msg || ld_conv;
      if (state_q == CONV) begin
        bcd_q <= bcd_d;
        bin_q <= bin_q << 1;
        bit_q <= bit_q + 1'b1;
        if (ld_conv) begin
          state_q <= SHOW;
          hold_q  <= '0;
        end
      end else begin
        if (state_q == SHOW && tick) hold_q <= hold_q + 1'b1;
        if (rearb) begin
          grant_q <= win;
          hold_q  <= '0;
          state_q <= win[2] ? SHOW : win != 3'd0 ? CONV : IDLE;
          bin_q   <= sat;
          bcd_q   <= '0;
          bit_q   <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_display_sched.sv
// tb_display_sched: table-driven and directed checks of display_sched with SCAN_DIV=4, HOLD_TICKS=8
module tb_display_sched;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] req = '0;
  logic [15:0] val0 = '0, val1 = '0, msg = '0;
  logic [2:0] grant;
  logic busy, conv_done;
  logic [3:0] digit;
  logic [1:0] pos;
  int checks = 0, failures = 0, k = 0;
`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [15:0] E7 = 16'hfff7, E0 = 16'hfff0, E305 = 16'hf305, E10 = 16'hff10;
`else
  localparam logic [15:0] E7 = 16'h0007, E0 = 16'h0000, E305 = 16'h0305, E10 = 16'h0010;
`endif
  typedef struct {
    logic [2:0]  r;
    logic [15:0] v0, v1, m;
    logic [2:0]  g;
    logic [15:0] d;
    int          b;
  } vec_t;
  vec_t tv[9];
  display_sched #(.SCAN_DIV(4), .HOLD_TICKS(8)) dut (
    .clk(clk), .rst(rst), .req(req), .val0(val0), .val1(val1), .msg(msg),
    .grant(grant), .busy(busy), .conv_done(conv_done), .digit(digit), .pos(pos)
  );
  always #5 clk = ~clk;
  always @(posedge clk) k <= rst ? 0 : k + 1;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (k=%0d)", n, a, e, k);
    end
  endtask
  task automatic chk_reset();
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(conv_done), 0);
    chk("rst_digit", int'(digit), 0);
    chk("rst_pos", int'(pos), 0);
  endtask
  task automatic start(input logic [2:0] r, input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] m);
    rst = 1'b1;
    req = r;
    val0 = v0;
    val1 = v1;
    msg = m;
    repeat (2) @(negedge clk);
    chk_reset();
    rst = 1'b0;
  endtask
  task automatic wait_done(input int exp_busy, input int exp_k, input logic [15:0] old_d);
    int b = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (conv_done) seen = 1'b1;
      else begin
        if (busy) b++;
        chk("old_digit", int'(digit), int'(old_d[4*((k/4)%4)+:4]));
      end
    end
    chk("done_seen", int'(seen), 1);
    chk("busy_clks", b, exp_busy);
    chk("done_at", k, exp_k);
  endtask
  task automatic watch(input int n, input logic [2:0] g, input logic [15:0] d);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("show_grant", int'(grant), int'(g));
      chk("show_pos", int'(pos), (k/4)%4);
      chk("show_digit", int'(digit), int'(d[4*((k/4)%4)+:4]));
      chk("show_busy", int'(busy), 0);
      chk("show_done", int'(conv_done), 0);
    end
  endtask
  initial begin
    tv[0] = '{3'b001, 16'd1234, 16'd0, 16'h0, 3'b001, 16'h1234, 16};
    tv[1] = '{3'b010, 16'd0, 16'd65535, 16'h0, 3'b010, 16'h9999, 16};
    tv[2] = '{3'b100, 16'd0, 16'd0, 16'h0a5b, 3'b100, 16'h0a5b, 0};
    tv[3] = '{3'b001, 16'd7, 16'd0, 16'h0, 3'b001, E7, 16};
    tv[4] = '{3'b001, 16'd0, 16'd0, 16'h0, 3'b001, E0, 16};
    tv[5] = '{3'b011, 16'd1111, 16'd10000, 16'h0, 3'b010, 16'h9999, 16};
    tv[6] = '{3'b111, 16'd1, 16'd2, 16'h1234, 3'b100, 16'h1234, 0};
    tv[7] = '{3'b001, 16'd305, 16'd0, 16'h0, 3'b001, E305, 16};
    tv[8] = '{3'b010, 16'd0, 16'd10, 16'h0, 3'b010, E10, 16};
    foreach (tv[i]) begin
      start(tv[i].r, tv[i].v0, tv[i].v1, tv[i].m);
      wait_done(tv[i].b, tv[i].b + 1, 16'h0);
      chk("vec_grant", int'(grant), int'(tv[i].g));
      watch(16, tv[i].g, tv[i].d);
    end
    start(3'b001, 16'd1234, 16'd0, 16'h0);
    wait_done(16, 17, 16'h0);
    req = 3'b101;
    msg = 16'h0a5b;
    repeat (2) begin
      @(negedge clk);
      chk("pre_wait", int'(grant), 1);
    end
    @(negedge clk);
    chk("pre_grant", int'(grant), 4);
    chk("pre_done", int'(conv_done), 1);
    chk("pre_busy", int'(busy), 0);
    watch(12, 3'b100, 16'h0a5b);
    start(3'b010, 16'd1234, 16'd4321, 16'h0);
    wait_done(16, 17, 16'h0);
    while (k < 25) @(negedge clk);
    req = 3'b001;
    while (k < 47) begin
      @(negedge clk);
      chk("hold_grant", int'(grant), 2);
      chk("hold_busy", int'(busy), 0);
    end
    @(negedge clk);
    chk("expire_grant", int'(grant), 1);
    chk("expire_busy", int'(busy), 1);
    wait_done(15, 64, 16'h4321);
    watch(8, 3'b001, 16'h1234);
    start(3'b001, 16'd1234, 16'd4321, 16'h0);
    wait_done(16, 17, 16'h0);
    while (k < 45) @(negedge clk);
    req = 3'b011;
    repeat (2) begin
      @(negedge clk);
      chk("tie_wait", int'(grant), 1);
    end
    @(negedge clk);
    chk("tie_grant", int'(grant), 2);
    chk("tie_busy", int'(busy), 1);
    wait_done(15, 64, 16'h1234);
    watch(4, 3'b010, 16'h4321);
    start(3'b001, 16'd1234, 16'd0, 16'h0);
    while (k < 5) @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset();
    rst = 1'b0;
    wait_done(16, 17, 16'h0);
    chk("restart_grant", int'(grant), 1);
    watch(8, 3'b001, 16'h1234);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
